// File: rtl/registered_gate_term_if.sv
// registered_gate_term_if: control, data and status bundle for registered_gate_term.
// The master drives Tick/Clear/Inputs; the slave (the gate) returns Comb/Result/Rise/MatchCount.
interface registered_gate_term_if #(
    parameter int unsigned NrOfInputs = 6
) ();

    localparam int unsigned CountW = 8;

    logic                    Tick;
    logic                    Clear;
    logic [NrOfInputs-1:0]   Inputs;
    logic                    Comb;
    logic                    Result;
    logic                    Rise;
    logic [CountW-1:0]       MatchCount;

    modport master (
        output Tick,
        output Clear,
        output Inputs,
        input  Comb,
        input  Result,
        input  Rise,
        input  MatchCount
    );

    modport slave (
        input  Tick,
        input  Clear,
        input  Inputs,
        output Comb,
        output Result,
        output Rise,
        output MatchCount
    );

endinterface

// File: rtl/registered_gate_term.sv
// registered_gate_term: bubble-inverted AND/OR/XOR/NAND reduction of an input bus,
// registered on Tick, stretched for StretchCycles ticks, with a one-clock rise pulse.
// Optional rise counter enabled by defining REGISTERED_GATE_TERM_COUNT_EN.
module registered_gate_term #(
    parameter int unsigned NrOfInputs    = 6,
    parameter logic [31:0] BubblesMask   = 32'd0,
    parameter int unsigned Mode          = 0,
    parameter int unsigned StretchCycles = 0
) (
    input  logic                  GlobalClock,
    input  logic                  Reset_n,
    registered_gate_term_if.slave bus
);

    localparam int unsigned HoldW = 8;
    localparam logic [NrOfInputs-1:0] MaskBits  = BubblesMask[NrOfInputs-1:0];
    localparam logic [HoldW-1:0]      StretchLd = HoldW'(StretchCycles);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_STRETCH = 2'd2;

    logic [NrOfInputs-1:0] real_c;
    logic                  comb_c;

    logic [1:0]            state_d, state_q;
    logic [HoldW-1:0]      hold_d,  hold_q;
    logic                  result_d, result_q;
    logic                  prev_d,   prev_q;
    logic                  rise_d,   rise_q;

    // Bubble inversion followed by the selected reduction.
    always_comb begin
        real_c = bus.Inputs ^ MaskBits;
        case (Mode)
            0:       comb_c = &real_c;
            1:       comb_c = |real_c;
            2:       comb_c = ^real_c;
            default: comb_c = ~&real_c;
        endcase
    end

    // Next state: clear wins, otherwise advance only on a tick.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        result_d = result_q;
        if (bus.Clear) begin
            state_d  = ST_IDLE;
            hold_d   = '0;
            result_d = 1'b0;
        end else if (bus.Tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (comb_c) begin
                        state_d  = ST_ACTIVE;
                        hold_d   = StretchLd;
                        result_d = 1'b1;
                    end
                end
                ST_ACTIVE, ST_STRETCH: begin
                    if (comb_c) begin
                        state_d  = ST_ACTIVE;
                        hold_d   = StretchLd;
                        result_d = 1'b1;
                    end else if (hold_q != '0) begin
                        state_d  = ST_STRETCH;
                        hold_d   = hold_q - HoldW'(1);
                        result_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        result_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    hold_d   = '0;
                    result_d = 1'b0;
                end
            endcase
        end
    end

    // Rising-edge detector runs every clock, independent of Tick.
    always_comb begin
        prev_d = result_q;
        rise_d = bus.Clear ? 1'b0 : (result_q & ~prev_q);
    end

    // State, stretch counter, result and edge-detect registers.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            result_q <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            result_q <= result_d;
            prev_q   <= prev_d;
            rise_q   <= rise_d;
        end
    end

    assign bus.Comb   = comb_c;
    assign bus.Result = result_q;
    assign bus.Rise   = rise_q;

`ifdef REGISTERED_GATE_TERM_COUNT_EN
    logic [7:0] count_d, count_q;

    // Saturating count of rise pulses; updates together with Rise.
    always_comb begin
        count_d = count_q;
        if (bus.Clear) begin
            count_d = '0;
        end else if (rise_d && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Rise counter register.
    always_ff @(posedge GlobalClock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.MatchCount = count_q;
`else
    assign bus.MatchCount = 8'd0;
`endif

endmodule

// File: tb/tb_registered_gate_term.sv
// tb_registered_gate_term: directed vectors for registered_gate_term across several
// parameter sets (AND with bubble, the four modes, stretch 3, stretch 2 with tick gating).
module tb_registered_gate_term;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    registered_gate_term_if #(.NrOfInputs(6)) bus_and ();
    registered_gate_term_if #(.NrOfInputs(4)) bus_m0 ();
    registered_gate_term_if #(.NrOfInputs(4)) bus_m1 ();
    registered_gate_term_if #(.NrOfInputs(4)) bus_m2 ();
    registered_gate_term_if #(.NrOfInputs(4)) bus_m3 ();
    registered_gate_term_if #(.NrOfInputs(4)) bus_str ();
    registered_gate_term_if #(.NrOfInputs(4)) bus_tk ();

    registered_gate_term #(.NrOfInputs(6), .BubblesMask(32'd1), .Mode(0), .StretchCycles(0))
        u_and (.GlobalClock(clk), .Reset_n(rst_n), .bus(bus_and));
    registered_gate_term #(.NrOfInputs(4), .BubblesMask(32'd0), .Mode(0), .StretchCycles(0))
        u_m0 (.GlobalClock(clk), .Reset_n(rst_n), .bus(bus_m0));
    registered_gate_term #(.NrOfInputs(4), .BubblesMask(32'd0), .Mode(1), .StretchCycles(0))
        u_m1 (.GlobalClock(clk), .Reset_n(rst_n), .bus(bus_m1));
    registered_gate_term #(.NrOfInputs(4), .BubblesMask(32'd0), .Mode(2), .StretchCycles(0))
        u_m2 (.GlobalClock(clk), .Reset_n(rst_n), .bus(bus_m2));
    registered_gate_term #(.NrOfInputs(4), .BubblesMask(32'd0), .Mode(3), .StretchCycles(0))
        u_m3 (.GlobalClock(clk), .Reset_n(rst_n), .bus(bus_m3));
    registered_gate_term #(.NrOfInputs(4), .BubblesMask(32'd0), .Mode(1), .StretchCycles(3))
        u_str (.GlobalClock(clk), .Reset_n(rst_n), .bus(bus_str));
    registered_gate_term #(.NrOfInputs(4), .BubblesMask(32'd0), .Mode(1), .StretchCycles(2))
        u_tk (.GlobalClock(clk), .Reset_n(rst_n), .bus(bus_tk));

    // Count one comparison and report it if the observed value differs.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_modes(input logic [3:0] v);
        bus_m0.Inputs = v;
        bus_m1.Inputs = v;
        bus_m2.Inputs = v;
        bus_m3.Inputs = v;
        #1;
    endtask

    // One isolated pulse on the AND gate (bubble on bit 0).
    task automatic pulse_and();
        bus_and.Inputs = 6'b111110;
        step();
        bus_and.Inputs = 6'b111111;
        repeat (3) step();
    endtask

    // Drive a Comb pattern into the stretch-3 gate, one bit per clock, checking Result and Rise.
    task automatic run_seq(input string tag, input logic [15:0] comb_bits,
                           input logic [15:0] res_bits, input logic [15:0] rise_bits,
                           input int n);
        for (int k = 0; k < n; k++) begin
            bus_str.Inputs = comb_bits[k] ? 4'b0001 : 4'b0000;
            step();
            check_eq($sformatf("%s_res%0d", tag, k), 32'(bus_str.Result), 32'(res_bits[k]));
            check_eq($sformatf("%s_rise%0d", tag, k), 32'(bus_str.Rise), 32'(rise_bits[k]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_and.Tick = 1'b1; bus_and.Clear = 1'b0; bus_and.Inputs = 6'b111111;
        bus_m0.Tick = 1'b1;  bus_m0.Clear = 1'b0;  bus_m0.Inputs = 4'b0101;
        bus_m1.Tick = 1'b1;  bus_m1.Clear = 1'b0;  bus_m1.Inputs = 4'b0101;
        bus_m2.Tick = 1'b1;  bus_m2.Clear = 1'b0;  bus_m2.Inputs = 4'b0101;
        bus_m3.Tick = 1'b1;  bus_m3.Clear = 1'b0;  bus_m3.Inputs = 4'b0101;
        bus_str.Tick = 1'b1; bus_str.Clear = 1'b0; bus_str.Inputs = 4'b0000;
        bus_tk.Tick = 1'b1;  bus_tk.Clear = 1'b0;  bus_tk.Inputs = 4'b0000;

        // Reset state
        repeat (2) step();
        check_eq("rst_result", 32'(bus_and.Result), 32'd0);
        check_eq("rst_rise", 32'(bus_and.Rise), 32'd0);
        check_eq("rst_count", 32'(bus_and.MatchCount), 32'd0);
        check_eq("rst_nand_result", 32'(bus_m3.Result), 32'd0);
        rst_n = 1'b1;
        step();

        // AND with bubble on bit 0
        bus_and.Inputs = 6'b111110;
        #1;
        check_eq("and_comb_on", 32'(bus_and.Comb), 32'd1);
        check_eq("and_res_before", 32'(bus_and.Result), 32'd0);
        step();
        check_eq("and_res_on", 32'(bus_and.Result), 32'd1);
        check_eq("and_rise_lat", 32'(bus_and.Rise), 32'd0);
        step();
        check_eq("and_rise_pulse", 32'(bus_and.Rise), 32'd1);
        bus_and.Inputs = 6'b111111;
        #1;
        check_eq("and_comb_off", 32'(bus_and.Comb), 32'd0);
        step();
        check_eq("and_res_off", 32'(bus_and.Result), 32'd0);
        check_eq("and_rise_end", 32'(bus_and.Rise), 32'd0);

        // Reduction modes
        set_modes(4'b0101);
        check_eq("m_and_0101", 32'(bus_m0.Comb), 32'd0);
        check_eq("m_or_0101", 32'(bus_m1.Comb), 32'd1);
        check_eq("m_xor_0101", 32'(bus_m2.Comb), 32'd0);
        check_eq("m_nand_0101", 32'(bus_m3.Comb), 32'd1);
        set_modes(4'b0111);
        check_eq("m_xor_0111", 32'(bus_m2.Comb), 32'd1);
        check_eq("m_and_0111", 32'(bus_m0.Comb), 32'd0);
        set_modes(4'b1111);
        check_eq("m_and_1111", 32'(bus_m0.Comb), 32'd1);
        check_eq("m_nand_1111", 32'(bus_m3.Comb), 32'd0);
        check_eq("m_xor_1111", 32'(bus_m2.Comb), 32'd0);
        set_modes(4'b0000);
        check_eq("m_or_0000", 32'(bus_m1.Comb), 32'd0);

        // Stretch 3: single sample, then retrigger on the 2nd stretch tick
        run_seq("str1", 16'b000001, 16'b001111, 16'b000010, 6);
        run_seq("str2", 16'b00000101, 16'b00111111, 16'b00000010, 8);

        // Tick gating: no tick while Comb toggles leaves Result idle
        bus_tk.Tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_tk.Inputs = k[0] ? 4'b0001 : 4'b0000;
            step();
            check_eq($sformatf("tk_idle%0d", k), 32'(bus_tk.Result), 32'd0);
        end
        bus_tk.Tick = 1'b1;
        bus_tk.Inputs = 4'b0010;
        step();
        check_eq("tk_on", 32'(bus_tk.Result), 32'd1);
        // Tick every 4th clock, Comb high only between ticks: stretch of 2 spans 8 more clocks
        for (int k = 1; k <= 12; k++) begin
            bus_tk.Tick = ((k % 4) == 0);
            bus_tk.Inputs = ((k % 4) == 0) ? 4'b0000 : (((k % 2) != 0) ? 4'b1000 : 4'b0000);
            step();
            check_eq($sformatf("tk_str%0d", k), 32'(bus_tk.Result), (k < 12) ? 32'd1 : 32'd0);
        end
        bus_tk.Tick = 1'b1;
        bus_tk.Inputs = 4'b0000;

        // Clear mid-stretch (hold = 2)
        bus_str.Inputs = 4'b0001;
        step();
        bus_str.Inputs = 4'b0000;
        step();
        bus_str.Clear = 1'b1;
        step();
        check_eq("clr_res", 32'(bus_str.Result), 32'd0);
        check_eq("clr_rise", 32'(bus_str.Rise), 32'd0);
        bus_str.Clear = 1'b0;
        step();
        check_eq("clr_res_after", 32'(bus_str.Result), 32'd0);

        // Async reset mid-stretch, release with Comb high
        bus_str.Inputs = 4'b0001;
        step();
        bus_str.Inputs = 4'b0000;
        step();
        check_eq("rst_mid_pre", 32'(bus_str.Rise), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_res", 32'(bus_str.Result), 32'd0);
        check_eq("rst_mid_rise", 32'(bus_str.Rise), 32'd0);
        bus_str.Inputs = 4'b0001;
        #1 rst_n = 1'b1;
        step();
        check_eq("rst_rel_res", 32'(bus_str.Result), 32'd1);
        step();
        check_eq("rst_rel_rise", 32'(bus_str.Rise), 32'd1);
        bus_str.Inputs = 4'b0000;
        repeat (5) step();
        check_eq("rst_rel_idle", 32'(bus_str.Result), 32'd0);

        // Match counter
        bus_and.Clear = 1'b1;
        step();
        bus_and.Clear = 1'b0;
        repeat (3) pulse_and();
`ifdef REGISTERED_GATE_TERM_COUNT_EN
        check_eq("cnt_three", 32'(bus_and.MatchCount), 32'd3);
`else
        check_eq("cnt_off_three", 32'(bus_and.MatchCount), 32'd0);
`endif
        bus_and.Inputs = 6'b111110;
        step();
        bus_and.Clear = 1'b1;
        bus_and.Inputs = 6'b111111;
        step();
        bus_and.Clear = 1'b0;
        check_eq("cnt_clr_rise", 32'(bus_and.Rise), 32'd0);
        check_eq("cnt_clr", 32'(bus_and.MatchCount), 32'd0);
        step();
        repeat (300) pulse_and();
`ifdef REGISTERED_GATE_TERM_COUNT_EN
        check_eq("cnt_sat", 32'(bus_and.MatchCount), 32'd255);
`else
        check_eq("cnt_off_sat", 32'(bus_and.MatchCount), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
